apb_req_arbiter: RTL and testbench
==================================

# apb_req_arbiter

Round-robin arbiter and sequencer that shares the single APB transfer engine of the AHB-to-APB bridge between N_REQ requesters. It captures the winning requester's address, size and write data, issues a one-cycle start strobe to the engine, holds the captured fields stable while the engine runs, and returns a done/error pulse to the owning requester. It sits between the bridge's AHB-side request sources and the APB engine.

## Interface
- AHB_AW, 32, address width of each requester and of the engine address output
- AHB_DW, 32, write-data width of each requester and of the engine data output
- N_REQ, 2, number of requesters; legal range 2..4
- PCLK  input  1  clock; all logic is on its rising edge
- PRESETn  input  1  reset, asynchronous, active-low
- i_req  input  N_REQ  per-requester request; held high until the matching o_done
- i_addr  input  N_REQ*AHB_AW  flattened addresses; requester k uses bits [k*AHB_AW +: AHB_AW]
- i_size  input  N_REQ*3  flattened HSIZE codes; requester k uses bits [k*3 +: 3]
- i_wdata  input  N_REQ*AHB_DW  flattened write data; requester k uses bits [k*AHB_DW +: AHB_DW]
- o_gnt  output  N_REQ  one-hot owner indication
- o_done  output  N_REQ  one-cycle completion pulse to the owner
- o_err  output  N_REQ  error flag, valid only with o_done
- o_start_transfer  output  1  one-cycle start strobe to the APB engine
- o_haddr  output  AHB_AW  captured address to the engine
- o_hsize  output  3  captured size to the engine
- o_hwdata  output  AHB_DW  captured write data to the engine
- i_done  input  1  engine completion pulse (its HREADY edge pulse)
- i_err  input  1  engine slave-error response, sampled only with i_done

## Operation
- States: ARB_IDLE, ARB_START, ARB_BUSY, ARB_DONE.
- ARB_IDLE: if any i_req bit is high, the winner is the first set bit searching upward from r_ptr and wrapping modulo N_REQ. On that edge, register the winner index, set o_gnt one-hot, capture the winner's addr/size/wdata into o_haddr/o_hsize/o_hwdata, and go to ARB_START. If no request is pending, stay in ARB_IDLE.
- ARB_START: o_start_transfer=1 for this cycle only. Unconditionally go to ARB_BUSY.
- ARB_BUSY: wait for i_done. On i_done, register o_done[g]=1 and o_err[g]=i_err, then go to ARB_DONE.
- ARB_DONE: o_done and o_err are high this one cycle. Set r_ptr to (g+1) mod N_REQ, clear o_gnt, and go to ARB_IDLE.
- i_done seen in any state other than ARB_BUSY is ignored.
- The engine outputs (o_haddr, o_hsize, o_hwdata) hold their captured values from the capture edge until the next capture. Requester inputs changing after capture have no effect.
- If i_req[g] drops during ARB_START or ARB_BUSY, the transfer still completes and the o_done pulse is still issued.
- Only one transfer is outstanding at a time. The block never asserts o_start_transfer while a transfer is in flight.

## Timing
- Reset (asynchronous, PRESETn low): state=ARB_IDLE and r_ptr=0. o_gnt, o_done, o_err, o_start_transfer, o_haddr, o_hsize and o_hwdata are all 0. The effect is immediate, including mid-transfer.
- Request to start: a request sampled in ARB_IDLE at edge n gives o_gnt and captured fields after edge n, o_start_transfer high in cycle n+1, and the engine in SETUP after edge n+2.
- Completion: i_done high in cycle m gives o_done/o_err high in cycle m+1.
- Arbitration: the earliest next arbitration is the ARB_IDLE cycle m+2. The minimum gap from o_done to the next o_start_transfer is 2 cycles.
- Fairness: under continuous requests from all requesters, grants rotate 0,1,..,N_REQ-1,0 with no requester starved.
- Simultaneous arrival: requests that arrive in the same ARB_IDLE cycle resolve purely by r_ptr order.
- o_gnt is one-hot or zero at all times. o_done and o_err never assert for a non-owner.

## Structure
- Shared package ahb2apb_pkg contains:
  - the ARB_* state encodings (2 bits);
  - the N_REQ_MAX=4 constant;
  - the HSIZE code constants.
- Sub-module rr_arbiter is purely combinational. Its inputs are i_req and r_ptr; its outputs are a one-hot winner and the winner index. The FSM, capture registers and pointer live in apb_req_arbiter.

## Test plan
- **Reset:** assert PRESETn low mid-ARB_BUSY. All outputs go to 0 and state returns to ARB_IDLE immediately. Requester 1 then requests after release and is granted first from r_ptr=0.
- **Single request:** requester 0 requests with addr 0x0000_1004, size 3'b010, wdata 0xDEAD_BEEF.
  - Required: o_start_transfer pulses once, one cycle after the request is sampled, and the engine outputs carry those values.
  - Drive i_done 5 cycles later. Required: o_done[0]=1 one cycle after i_done, with o_err[0]=0.
- **Contention:** requesters 0 and 1 request in the same cycle and hold. Grants go 0,1,0,1 over four transfers, with exactly one o_start_transfer per transfer.
- **Error and capture hold:**
  - Drive i_err=1 with i_done. Required: o_err of the owner is 1 in its o_done cycle.
  - Change i_addr of the owner during ARB_BUSY. Required: o_haddr is unchanged.
- **Spurious and dropped:**
  - Pulse i_done in ARB_IDLE. Required: no o_done.
  - Drop i_req[1] during ARB_BUSY. Required: o_done[1] still fires after i_done.
- **N_REQ=4 wrap:** requesters 3 and 0 request with r_ptr=3. Requester 3 wins, then requester 0 wins with r_ptr wrapped to 0.

Source files
------------

// File: rtl/ahb2apb_pkg.sv
// Shared definitions for the AHB-to-APB bridge: arbiter state encodings,
// requester-count limit and AHB HSIZE codes.
package ahb2apb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_START = 2'd1,
    ARB_BUSY  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

  localparam int N_REQ_MAX = 4;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx
);

  logic found;
  int   k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int off = 0; off < N_REQ; off++) begin
      k = (int'(ptr) + off) % N_REQ;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB transfer engine between N_REQ requesters: round-robin pick,
// field capture, single start strobe, and done/error return to the owner.
module apb_req_arbiter
  import ahb2apb_pkg::*;
#(
  parameter int AHB_AW = 32,
  parameter int AHB_DW = 32,
  parameter int N_REQ  = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*AHB_AW-1:0] i_addr,
  input  logic [N_REQ*3-1:0]      i_size,
  input  logic [N_REQ*AHB_DW-1:0] i_wdata,
  output logic [N_REQ-1:0]        o_gnt,
  output logic [N_REQ-1:0]        o_done,
  output logic [N_REQ-1:0]        o_err,
  output logic                    o_start_transfer,
  output logic [AHB_AW-1:0]       o_haddr,
  output logic [2:0]              o_hsize,
  output logic [AHB_DW-1:0]       o_hwdata,
  input  logic                    i_done,
  input  logic                    i_err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t        state;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     owner;
  logic [IW-1:0]     win_idx;
  logic [N_REQ-1:0]  win_oh;

  logic [AHB_AW-1:0] addr_arr  [N_REQ];
  logic [2:0]        size_arr  [N_REQ];
  logic [AHB_DW-1:0] wdata_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = i_addr[gi*AHB_AW +: AHB_AW];
      assign size_arr[gi]  = i_size[gi*3 +: 3];
      assign wdata_arr[gi] = i_wdata[gi*AHB_DW +: AHB_DW];
    end
  endgenerate

  rr_arbiter #(
    .N_REQ(N_REQ),
    .IW   (IW)
  ) u_rr (
    .req(i_req),
    .ptr(ptr),
    .gnt(win_oh),
    .idx(win_idx)
  );

  // o_gnt stays one-hot for the whole transfer, so it doubles as the
  // done/error routing mask.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state            <= ARB_IDLE;
      ptr              <= '0;
      owner            <= '0;
      o_gnt            <= '0;
      o_done           <= '0;
      o_err            <= '0;
      o_start_transfer <= 1'b0;
      o_haddr          <= '0;
      o_hsize          <= '0;
      o_hwdata         <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|i_req) begin
            owner            <= win_idx;
            o_gnt            <= win_oh;
            o_haddr          <= addr_arr[win_idx];
            o_hsize          <= size_arr[win_idx];
            o_hwdata         <= wdata_arr[win_idx];
            o_start_transfer <= 1'b1;
            state            <= ARB_START;
          end
        end
        ARB_START: begin
          o_start_transfer <= 1'b0;
          state            <= ARB_BUSY;
        end
        ARB_BUSY: begin
          if (i_done) begin
            o_done <= o_gnt;
            o_err  <= i_err ? o_gnt : '0;
            state  <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          o_done <= '0;
          o_err  <= '0;
          o_gnt  <= '0;
          ptr    <= (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);
          state  <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomized transaction-level check of apb_req_arbiter (N_REQ=4) against a
// round-robin reference model tracking only the pointer and expected timing.
module tb_apb_req_arbiter;

  logic         PCLK = 1'b0;
  logic         PRESETn;
  logic [3:0]   i_req;
  logic [127:0] i_addr;
  logic [11:0]  i_size;
  logic [127:0] i_wdata;
  logic [3:0]   o_gnt;
  logic [3:0]   o_done;
  logic [3:0]   o_err;
  logic         o_start_transfer;
  logic [31:0]  o_haddr;
  logic [2:0]   o_hsize;
  logic [31:0]  o_hwdata;
  logic         i_done;
  logic         i_err;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;

  apb_req_arbiter #(
    .AHB_AW(32),
    .AHB_DW(32),
    .N_REQ (4)
  ) dut (
    .PCLK            (PCLK),
    .PRESETn         (PRESETn),
    .i_req           (i_req),
    .i_addr          (i_addr),
    .i_size          (i_size),
    .i_wdata         (i_wdata),
    .o_gnt           (o_gnt),
    .o_done          (o_done),
    .o_err           (o_err),
    .o_start_transfer(o_start_transfer),
    .o_haddr         (o_haddr),
    .o_hsize         (o_hsize),
    .o_hwdata        (o_hwdata),
    .i_done          (i_done),
    .i_err           (i_err)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: first requester at or after the pointer, wrapping over 4.
  function automatic int rr_pick(input int p, input logic [3:0] r);
    for (int off = 0; off < 4; off++)
      if (r[(p + off) % 4]) return (p + off) % 4;
    return 0;
  endfunction

  task automatic scramble_inputs();
    for (int k = 0; k < 4; k++) begin
      i_addr[k*32 +: 32]  = $urandom;
      i_wdata[k*32 +: 32] = $urandom;
      i_size[k*3 +: 3]    = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic run_xfer(input logic [3:0] req, input int delay, input bit err,
                          input bit spur, input bit drop, input bit fixed);
    int          w;
    logic [3:0]  oh;
    logic [31:0] ea, ew;
    logic [2:0]  es;
    @(negedge PCLK);
    scramble_inputs();
    if (fixed) begin
      i_addr[31:0]  = 32'h0000_1004;
      i_size[2:0]   = 3'b010;
      i_wdata[31:0] = 32'hDEAD_BEEF;
    end
    i_req = req;
    w  = rr_pick(ptr_m, req);
    oh = 4'b0001 << w;
    ea = i_addr[w*32 +: 32];
    ew = i_wdata[w*32 +: 32];
    es = i_size[w*3 +: 3];
    check_val("idle_no_start", 64'(o_start_transfer), 64'd0);
    @(posedge PCLK); @(negedge PCLK);
    check_val("gnt", 64'(o_gnt), 64'(oh));
    check_val("start_pulse", 64'(o_start_transfer), 64'd1);
    check_val("haddr", 64'(o_haddr), 64'(ea));
    check_val("hsize", 64'(o_hsize), 64'(es));
    check_val("hwdata", 64'(o_hwdata), 64'(ew));
    scramble_inputs();
    if (spur) begin
      i_done = 1'b1;
      i_err  = 1'b1;
    end
    @(posedge PCLK); @(negedge PCLK);
    i_done = 1'b0;
    i_err  = 1'b0;
    check_val("start_once", 64'(o_start_transfer), 64'd0);
    check_val("no_early_done", 64'(o_done), 64'd0);
    check_val("haddr_hold", 64'(o_haddr), 64'(ea));
    if (drop) i_req[w] = 1'b0;
    for (int c = 0; c < delay; c++) begin
      scramble_inputs();
      @(posedge PCLK); @(negedge PCLK);
      check_val("busy_start", 64'(o_start_transfer), 64'd0);
      check_val("busy_done", 64'(o_done), 64'd0);
      check_val("busy_haddr", 64'(o_haddr), 64'(ea));
      check_val("busy_hwdata", 64'(o_hwdata), 64'(ew));
      check_val("busy_gnt", 64'(o_gnt), 64'(oh));
    end
    i_done = 1'b1;
    i_err  = err;
    @(posedge PCLK); @(negedge PCLK);
    i_done = 1'b0;
    i_err  = 1'b0;
    check_val("done", 64'(o_done), 64'(oh));
    check_val("err", 64'(o_err), err ? 64'(oh) : 64'd0);
    check_val("done_no_start", 64'(o_start_transfer), 64'd0);
    $display("xfer req=%b ptr=%0d winner=%0d delay=%0d err=%0b spur=%0b drop=%0b addr=%h",
             req, ptr_m, w, delay, err, spur, drop, ea);
    i_req = 4'b0000;
    @(posedge PCLK); @(negedge PCLK);
    check_val("done_clear", 64'(o_done), 64'd0);
    check_val("err_clear", 64'(o_err), 64'd0);
    check_val("gnt_clear", 64'(o_gnt), 64'd0);
    ptr_m = (w + 1) % 4;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_gnt"}, 64'(o_gnt), 64'd0);
    check_val({tag, "_done"}, 64'(o_done), 64'd0);
    check_val({tag, "_err"}, 64'(o_err), 64'd0);
    check_val({tag, "_start"}, 64'(o_start_transfer), 64'd0);
    check_val({tag, "_haddr"}, 64'(o_haddr), 64'd0);
    check_val({tag, "_hsize"}, 64'(o_hsize), 64'd0);
    check_val({tag, "_hwdata"}, 64'(o_hwdata), 64'd0);
  endtask

  initial begin
    PRESETn = 1'b0;
    i_req   = '0;
    i_addr  = '0;
    i_size  = '0;
    i_wdata = '0;
    i_done  = 1'b0;
    i_err   = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;

    // single request with fixed fields, done 5 cycles into BUSY
    run_xfer(4'b0001, 5, 1'b0, 1'b0, 1'b0, 1'b1);

    // spurious done while idle
    @(negedge PCLK);
    i_done = 1'b1;
    i_err  = 1'b1;
    @(posedge PCLK); @(negedge PCLK);
    i_done = 1'b0;
    i_err  = 1'b0;
    check_val("spur_idle_done", 64'(o_done), 64'd0);
    check_val("spur_idle_start", 64'(o_start_transfer), 64'd0);
    @(posedge PCLK); @(negedge PCLK);
    check_val("spur_idle_done2", 64'(o_done), 64'd0);

    // contention between 0 and 1 (pointer now 1)
    for (int t = 0; t < 4; t++)
      run_xfer(4'b0011, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    // error response, dropped request, spurious done during START
    run_xfer(4'b0010, 2, 1'b1, 1'b1, 1'b1, 1'b0);

    // wrap: move pointer to 3, then 3 then 0
    run_xfer(4'b0100, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_xfer(4'b1001, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_xfer(4'b1001, 1, 1'b1, 1'b0, 1'b0, 1'b0);

    // reset mid-BUSY with pointer at 2
    run_xfer(4'b0010, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge PCLK);
    i_req = 4'b0100;
    @(posedge PCLK); @(negedge PCLK);
    @(posedge PCLK); @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    check_all_zero("midreset");
    i_req = 4'b0000;
    @(negedge PCLK);
    PRESETn = 1'b1;
    ptr_m = 0;
    run_xfer(4'b1010, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    // randomized traffic
    for (int t = 0; t < 30; t++)
      run_xfer(4'($urandom_range(1, 15)), int'($urandom_range(0, 6)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
